sbqm_queue_ctrl: RTL and testbench
==================================

// Module: sbqm_queue_ctrl
// PURPOSE
//  Clocked, parametrised single-bank queue manager. Counts customers from the back/forward
//  photo sensors and computes the estimated wait time with a multicycle divider instead of
//  a lookup ROM. Raises full/empty and sticky overflow/underflow flags.
//  Sits between the raw sensor pins/teller-count switches and the display/status logic.
// PARAMETERS
//  N      3    count width; queue capacity = 2**N-1 customers
//  TW     2    Tcount width; teller count range 0..2**TW-1
//  SVC    3    service time per customer, in time units
//  WW     N+2  Wtime width; must satisfy SVC*(2**N-1+2**TW-2) < 2**WW
// PORTS
//  clk           in   1    system clock, rising edge
//  reset         in   1    asynchronous, active-low reset
//  backphoto     in   1    raw sensor, customer enters at back (async to clk)
//  forwardphoto  in   1    raw sensor, customer leaves at front (async to clk)
//  Tcount        in   TW   number of open tellers, quasi-static
//  err_clr       in   1    sync pulse; clears ovf and unf
//  Pcount        out  N    customers in queue
//  Wtime         out  WW   estimated wait = SVC*(Pcount+Tcount-1)/Tcount, floor
//  wtime_valid   out  1    Wtime matches current Pcount/Tcount
//  full          out  1    Pcount == 2**N-1
//  empty         out  1    Pcount == 0
//  ovf           out  1    sticky: entry attempted while full
//  unf           out  1    sticky: exit attempted while empty
//  terr          out  1    Tcount == 0, combinational
// BEHAVIOUR
//  Reset: Pcount=0, Wtime=0, wtime_valid=1, empty=1, full=0, ovf=0, unf=0, FSM=IDLE.
//  Sensor path:
//   - Each sensor passes a 2-flop synchroniser, then a history flop.
//   - Event = rising edge (sync=1, hist=0).
//   - All three flops reset to 1: a sensor held high through reset release is not an event.
//   - Event-to-Pcount latency is 3 clk from the raw rising edge.
//  Count update, per cycle (bk=back event, fw=forward event):
//   bk only: if !full Pcount+1, else Pcount holds and ovf<=1.
//   fw only: if !empty Pcount-1, else Pcount holds and unf<=1.
//   bk&fw:   Pcount holds, no flag set, including when full or empty.
//   No wrap-around ever occurs.
//   err_clr clears ovf/unf; a same-cycle set wins over clear.
//  full and empty are registered and decoded from the next Pcount, so they change in the
//   same cycle as Pcount.
//  Wtime FSM (IDLE, CALC, DONE):
//   IDLE: a change in Pcount, or in Tcount (sampled each clk), triggers the FSM.
//   Trigger with Pcount==0, or Tcount==0: load Wtime=0 and go to DONE next cycle.
//   Any other trigger: latch num=SVC*(P+T-1) and den=T; CALC runs WW restoring-division steps.
//   Restart rule: a new trigger in CALC restarts CALC with fresh operands.
//   CALC->DONE: after WW steps, Wtime <= quotient.
//   DONE->IDLE: wtime_valid<=1.
//   wtime_valid=0 from the trigger cycle until DONE; Wtime holds its old value meanwhile.
//   Latency from the Pcount change to wtime_valid=1 is WW+2 clk, absent restarts.
//  Reset mid-operation returns all state to the reset values immediately.
// TESTING
//  1. Release reset with backphoto held high -> Pcount stays 0; empty=1, wtime_valid=1.
//  2. Tcount=1, 3 back pulses -> Pcount=3; final Wtime=9 (3*3/1), valid WW+2 clk after last count.
//  3. Tcount=3, Pcount=7 -> Wtime=9 (3*9/3); change Tcount to 2 -> valid drops, then Wtime=12.
//  4. Fill to 7, one more back pulse -> Pcount=7, full=1, ovf=1; err_clr -> ovf=0.
//  5. Empty queue, forward pulse -> Pcount=0, unf=1; simultaneous back+forward at Pcount=7 -> holds 7, ovf stays 0.
//  6. Tcount=0 -> terr=1, Wtime=0; back pulse during CALC -> restart; Wtime reflects new Pcount.

Source files
------------

// File: rtl/sbqm_queue_ctrl.sv
// Single-bank queue manager: synchronises the photo sensors, tracks the queue length with
// saturating counts and sticky error flags, and computes the estimated wait with a restoring divider.
module sbqm_queue_ctrl #(
  parameter int N   = 3,
  parameter int TW  = 2,
  parameter int SVC = 3,
  parameter int WW  = N + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          backphoto,
  input  logic          forwardphoto,
  input  logic [TW-1:0] Tcount,
  input  logic          err_clr,
  output logic [N-1:0]  Pcount,
  output logic [WW-1:0] Wtime,
  output logic          wtime_valid,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  output logic          terr
);

  localparam logic [N-1:0] PMAX = {N{1'b1}};
  localparam int           SW   = $clog2(WW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  logic [2:0]    bk_pipe_r, fw_pipe_r;
  logic          bk_s, fw_s;
  logic [N-1:0]  pcount_r, pcount_nxt_s, pseen_r;
  logic          full_r, empty_r, ovf_r, unf_r;
  logic          ovf_set_s, unf_set_s, cnt_chg_s;
  logic [TW-1:0] tcount_r, tseen_r;
  logic          trigger_s;

  state_t        state_r, state_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic [WW-1:0] wtime_r, wtime_nxt_s;
  logic [WW-1:0] quo_r, quo_nxt_s, quo_step_s, num_s;
  logic [TW-1:0] rem_r, rem_nxt_s, rem_step_s;
  logic [TW-1:0] den_r, den_nxt_s;
  logic [SW-1:0] step_r, step_nxt_s;
  logic [TW:0]   rem_sh_s;
  logic          ge_s;

  // Sensor synchroniser + history; ones at reset so a sensor held high is not an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bk_pipe_r <= 3'b111;
      fw_pipe_r <= 3'b111;
    end else begin
      bk_pipe_r <= {bk_pipe_r[1:0], backphoto};
      fw_pipe_r <= {fw_pipe_r[1:0], forwardphoto};
    end
  end

  assign bk_s = bk_pipe_r[1] & ~bk_pipe_r[2];
  assign fw_s = fw_pipe_r[1] & ~fw_pipe_r[2];

  // Next queue length with saturation and error-flag requests.
  always_comb begin
    pcount_nxt_s = pcount_r;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    case ({bk_s, fw_s})
      2'b10: begin
        if (full_r) ovf_set_s = 1'b1;
        else        pcount_nxt_s = pcount_r + {{(N-1){1'b0}}, 1'b1};
      end
      2'b01: begin
        if (empty_r) unf_set_s = 1'b1;
        else         pcount_nxt_s = pcount_r - {{(N-1){1'b0}}, 1'b1};
      end
      default: pcount_nxt_s = pcount_r;
    endcase
  end

  assign cnt_chg_s = (pcount_nxt_s != pcount_r);

  // Queue length, decoded status and sticky flags; a same-cycle set beats err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcount_r <= {N{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      pcount_r <= pcount_nxt_s;
      full_r   <= (pcount_nxt_s == PMAX);
      empty_r  <= (pcount_nxt_s == {N{1'b0}});
      ovf_r    <= ovf_set_s | (ovf_r & ~err_clr);
      unf_r    <= unf_set_s | (unf_r & ~err_clr);
    end
  end

  // Change detectors feeding the wait-time trigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount_r <= {TW{1'b0}};
      tseen_r  <= {TW{1'b0}};
      pseen_r  <= {N{1'b0}};
    end else begin
      tcount_r <= Tcount;
      tseen_r  <= tcount_r;
      pseen_r  <= pcount_r;
    end
  end

  assign trigger_s = (pcount_r != pseen_r) || (tcount_r != tseen_r);
  assign num_s     = WW'(SVC) * (WW'(pcount_r) + WW'(tcount_r) - WW'(1));

  // One restoring-division step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_sh_s   = {rem_r, quo_r[WW-1]};
    ge_s       = (rem_sh_s >= {1'b0, den_r});
    quo_step_s = {quo_r[WW-2:0], ge_s};
    if (ge_s) rem_step_s = TW'(rem_sh_s - {1'b0, den_r});
    else      rem_step_s = rem_sh_s[TW-1:0];
  end

  // Wait-time FSM: any trigger (re)starts the computation, overriding the current state.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = valid_r;
    wtime_nxt_s = wtime_r;
    quo_nxt_s   = quo_r;
    rem_nxt_s   = rem_r;
    den_nxt_s   = den_r;
    step_nxt_s  = step_r;
    if (trigger_s) begin
      valid_nxt_s = 1'b0;
      if ((pcount_r == {N{1'b0}}) || (tcount_r == {TW{1'b0}})) begin
        wtime_nxt_s = {WW{1'b0}};
        state_nxt_s = DONE;
      end else begin
        quo_nxt_s   = num_s;
        rem_nxt_s   = {TW{1'b0}};
        den_nxt_s   = tcount_r;
        step_nxt_s  = {SW{1'b0}};
        state_nxt_s = CALC;
      end
    end else begin
      case (state_r)
        CALC: begin
          quo_nxt_s  = quo_step_s;
          rem_nxt_s  = rem_step_s;
          step_nxt_s = step_r + SW'(1);
          if (step_r == SW'(WW - 1)) begin
            wtime_nxt_s = quo_step_s;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end
        DONE: begin
          valid_nxt_s = 1'b1;
          state_nxt_s = IDLE;
        end
        IDLE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
    // A count change invalidates Wtime in the very cycle Pcount moves.
    if (cnt_chg_s) valid_nxt_s = 1'b0;
    else           valid_nxt_s = valid_nxt_s;
  end

  // FSM state and divider datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      valid_r <= 1'b1;
      wtime_r <= {WW{1'b0}};
      quo_r   <= {WW{1'b0}};
      rem_r   <= {TW{1'b0}};
      den_r   <= {TW{1'b0}};
      step_r  <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      valid_r <= valid_nxt_s;
      wtime_r <= wtime_nxt_s;
      quo_r   <= quo_nxt_s;
      rem_r   <= rem_nxt_s;
      den_r   <= den_nxt_s;
      step_r  <= step_nxt_s;
    end
  end

  assign Pcount      = pcount_r;
  assign Wtime       = wtime_r;
  assign wtime_valid = valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign ovf         = ovf_r;
  assign unf         = unf_r;
  assign terr        = (Tcount == {TW{1'b0}});

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Directed bench for sbqm_queue_ctrl: a vector table of sensor pulses and teller counts with
// hand-computed queue/wait results, plus sequences for latency, restart and reset corners.
module tb_sbqm_queue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       backphoto, forwardphoto, err_clr;
  logic [1:0] Tcount;
  logic [2:0] Pcount;
  logic [4:0] Wtime;
  logic       wtime_valid, full, empty, ovf, unf, terr;

  int errors = 0;
  int checks = 0;
  logic saw_low;

  typedef struct {
    logic       bk;
    logic       fw;
    logic [1:0] t;
    logic       clr;
    logic [2:0] p;
    logic [4:0] w;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       terr;
    logic       drop;
  } vec_t;

  vec_t vecs[20];

  sbqm_queue_ctrl #(.N(3), .TW(2), .SVC(3), .WW(5)) dut (
    .clk(clk), .reset(reset), .backphoto(backphoto), .forwardphoto(forwardphoto),
    .Tcount(Tcount), .err_clr(err_clr), .Pcount(Pcount), .Wtime(Wtime),
    .wtime_valid(wtime_valid), .full(full), .empty(empty), .ovf(ovf), .unf(unf), .terr(terr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!wtime_valid) saw_low = 1'b1;
  endtask

  task automatic pulse(input logic bk, input logic fw);
    backphoto = bk;
    forwardphoto = fw;
    tick();
    tick();
    backphoto = 1'b0;
    forwardphoto = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!wtime_valid && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.clr) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
    end
    saw_low = 1'b0;
    Tcount = v.t;
    if (v.bk || v.fw) pulse(v.bk, v.fw);
    repeat (12) tick();
    chk({tag, "_pcount"}, 32'(Pcount), 32'(v.p));
    chk({tag, "_wtime"}, 32'(Wtime), 32'(v.w));
    chk({tag, "_valid"}, 32'(wtime_valid), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'(v.full));
    chk({tag, "_empty"}, 32'(empty), 32'(v.empty));
    chk({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
    chk({tag, "_unf"}, 32'(unf), 32'(v.unf));
    chk({tag, "_terr"}, 32'(terr), 32'(v.terr));
    chk({tag, "_drop"}, 32'(saw_low), 32'(v.drop));
  endtask

  initial begin
    //               bk    fw    t     clr   p     w       full  empty ovf   unf   terr  drop
    vecs[0]  = '{1'b1, 1'b0, 2'd1, 1'b0, 3'd4, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'd3, 1'b0, 3'd5, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 1'b0, 3'd6, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 1'b0, 3'd7, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 3'd7, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 3'd7, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 1'b1, 3'd7, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd7, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd6, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 3'd5, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd4, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd3, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd2, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 3'd1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 2'd3, 1'b0, 3'd1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with the back sensor held high.
    reset = 1'b0;
    backphoto = 1'b1;
    forwardphoto = 1'b0;
    err_clr = 1'b0;
    Tcount = 2'd1;
    saw_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pcount", 32'(Pcount), 32'd0);
    chk("rst_wtime", 32'(Wtime), 32'd0);
    chk("rst_valid", 32'(wtime_valid), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    chk("held_pcount", 32'(Pcount), 32'd0);
    chk("held_empty", 32'(empty), 32'd1);
    chk("held_valid", 32'(wtime_valid), 32'd1);
    backphoto = 1'b0;
    repeat (4) tick();

    // Three entries with one teller; latency checks on the last one.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("two_pcount", 32'(Pcount), 32'd2);
    backphoto = 1'b1;
    tick();
    tick();
    chk("lat2_pcount", 32'(Pcount), 32'd2);
    backphoto = 1'b0;
    tick();
    chk("lat3_pcount", 32'(Pcount), 32'd3);
    chk("lat3_valid", 32'(wtime_valid), 32'd0);
    wait_valid("wtime_latency", 7);
    chk("three_wtime", 32'(Wtime), 32'd9);

    for (int i = 0; i < 20; i++) apply_vec(i, vecs[i]);

    // Second entry lands while the divider is busy with the first: restart.
    pulse(1'b1, 1'b0);
    chk("rs_first_pcount", 32'(Pcount), 32'd2);
    backphoto = 1'b1;
    tick();
    tick();
    backphoto = 1'b0;
    tick();
    chk("rs_pcount", 32'(Pcount), 32'd3);
    chk("rs_valid", 32'(wtime_valid), 32'd0);
    wait_valid("rs_latency", 7);
    chk("rs_wtime", 32'(Wtime), 32'd5);

    // Asynchronous reset in the middle of a computation.
    pulse(1'b1, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_pcount", 32'(Pcount), 32'd0);
    chk("mid_rst_valid", 32'(wtime_valid), 32'd1);
    chk("mid_rst_wtime", 32'(Wtime), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
